// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latching interrupt controller in front of the 6502 core.
// NSRC maskable sources plus NMI, 4-register window, 1-cycle read latency.
module irq_ctrl #(
   parameter logic [15:0] BASE = 16'hD000,
   parameter int unsigned NSRC = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [15:0]     AB,
   input  logic [7:0]      DO,
   input  logic            WE,
   input  logic            RDY,
   input  logic [NSRC-1:0] src,
   input  logic            nmi_src,
   output logic [7:0]      rd_data,
   output logic            sel,
   output logic            IRQ,
   output logic            NMI
);

   localparam logic [7:0] MASK = 8'((9'd1 << NSRC) - 9'd1);

   logic [NSRC-1:0] s1_q, s2_q, prev_q;
   logic            nmi_s1_q, nmi_s2_q, nmi_prev_q;
   logic [1:0]      arm_q;
   logic [7:0]      pend_q, pend_d;
   logic [7:0]      en_q, en_d;
   logic            nmi_pend_q, nmi_pend_d;
   logic [7:0]      rd_data_q, rd_d;
   logic            sel_q;
   logic            hit, wr, armed, nmi_rise;
   logic [1:0]      off;
   logic [7:0]      rise, act, cause;
   logic [2:0]      idx;

   assign hit      = AB[15:2] == BASE[15:2];
   assign off      = AB[1:0];
   assign wr       = hit & WE & RDY;
   assign armed    = arm_q == 2'd3;
   assign act      = pend_q & en_q;
   assign nmi_rise = armed & nmi_s2_q & ~nmi_prev_q;

   always_comb begin
      rise = '0;
      rise[NSRC-1:0] = s2_q & ~prev_q;
      if (!armed) rise = '0;
   end

   // Descending scan so the lowest active index wins.
   always_comb begin
      idx = '0;
      for (int i = 7; i >= 0; i--)
         if (act[i]) idx = 3'(i);
      cause = (act != '0) ? {5'b10000, idx} : 8'h00;
   end

   // Clears are applied first, then new edges OR in, so a set always wins.
   always_comb begin
      pend_d     = pend_q;
      en_d       = en_q;
      nmi_pend_d = nmi_pend_q;
      if (wr) begin
         case (off)
            2'd0:    pend_d = pend_q & ~DO;
            2'd1:    en_d = DO & MASK;
            2'd3:    if (DO[0]) nmi_pend_d = 1'b0;
            default: ;
         endcase
      end
      pend_d     = (pend_d | rise) & MASK;
      nmi_pend_d = nmi_pend_d | nmi_rise;
   end

   always_comb begin
      case (off)
         2'd0:    rd_d = pend_q;
         2'd1:    rd_d = en_q;
         2'd2:    rd_d = cause;
         default: rd_d = {7'b0, nmi_pend_q};
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q       <= '0;
         s2_q       <= '0;
         prev_q     <= '0;
         nmi_s1_q   <= 1'b0;
         nmi_s2_q   <= 1'b0;
         nmi_prev_q <= 1'b0;
         arm_q      <= 2'd0;
         pend_q     <= 8'h00;
         en_q       <= 8'h00;
         nmi_pend_q <= 1'b0;
         rd_data_q  <= 8'h00;
         sel_q      <= 1'b0;
      end else begin
         s1_q       <= src;
         s2_q       <= s1_q;
         prev_q     <= s2_q;
         nmi_s1_q   <= nmi_src;
         nmi_s2_q   <= nmi_s1_q;
         nmi_prev_q <= nmi_s2_q;
         if (!armed) arm_q <= arm_q + 2'd1;
         pend_q     <= pend_d;
         en_q       <= en_d;
         nmi_pend_q <= nmi_pend_d;
         rd_data_q  <= rd_d;
         sel_q      <= hit;
      end
   end

   assign rd_data = rd_data_q;
   assign sel     = sel_q;
   assign IRQ     = ~|act;
   assign NMI     = ~nmi_pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed test-plan sequence plus randomized bus/source traffic,
// checked every cycle against a sample-history model of the controller.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] AB = 16'h0000;
   logic [7:0]  DO = 8'h00;
   logic        WE = 1'b0;
   logic        RDY = 1'b1;
   logic [7:0]  src = 8'h00;
   logic        nmi_src = 1'b0;
   logic [7:0]  rd_data;
   logic        sel, IRQ, NMI;

   int errors = 0;
   int checks = 0;

   irq_ctrl dut (
      .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE), .RDY(RDY),
      .src(src), .nmi_src(nmi_src), .rd_data(rd_data), .sel(sel),
      .IRQ(IRQ), .NMI(NMI)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   // Model: hist[n] is the {nmi_src,src} value sampled at the n-th edge
   // after reset (hist[0] = reset state). A bit becomes pending at edge n
   // when it was low at sample n-3 and high at n-2, and only from edge 4 on.
   logic [8:0] hist[$];
   logic [7:0] m_pend = 8'h00, m_en = 8'h00, m_rd = 8'h00;
   logic       m_nmi = 1'b0, m_sel = 1'b0;

   function automatic logic [7:0] m_reg(input logic [1:0] o);
      logic [7:0] a;
      a = m_pend & m_en;
      case (o)
         2'd0: return m_pend;
         2'd1: return m_en;
         2'd2: begin
            for (int i = 0; i < 8; i++)
               if (a[i]) return 8'h80 | 8'(i);
            return 8'h00;
         end
         default: return {7'b0, m_nmi};
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      int n;
      logic [8:0] r;
      logic [7:0] p, e;
      logic nm, h;
      if (reset) begin
         hist.delete();
         hist.push_back(9'h000);
         m_pend <= 8'h00;
         m_en   <= 8'h00;
         m_nmi  <= 1'b0;
         m_sel  <= 1'b0;
         m_rd   <= 8'h00;
      end else begin
         n  = hist.size();
         h  = (AB >= 16'hD000) && (AB <= 16'hD003);
         r  = (n >= 4) ? (hist[n-2] & ~hist[n-3]) : 9'h000;
         p  = m_pend;
         e  = m_en;
         nm = m_nmi;
         if (h && WE && RDY) begin
            if (AB[1:0] == 2'd0) p = p & ~DO;
            if (AB[1:0] == 2'd1) e = DO;
            if (AB[1:0] == 2'd3 && DO[0]) nm = 1'b0;
         end
         m_sel  <= h;
         m_rd   <= m_reg(AB[1:0]);
         m_pend <= p | r[7:0];
         m_en   <= e;
         m_nmi  <= nm | r[8];
         hist.push_back({nmi_src, src});
      end
   end

   always @(negedge clk) begin
      chk("sel", {7'd0, sel}, {7'd0, m_sel});
      if (m_sel) chk("rd_data", rd_data, m_rd);
      chk("IRQ", {7'd0, IRQ}, {7'd0, ~|(m_pend & m_en)});
      chk("NMI", {7'd0, NMI}, {7'd0, ~m_nmi});
   end

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d, input logic r);
      AB = a; DO = d; WE = 1'b1; RDY = r;
      @(negedge clk);
      WE = 1'b0; AB = 16'h0000; RDY = 1'b1;
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [7:0] d, output logic s);
      AB = a; WE = 1'b0;
      @(negedge clk);
      d = rd_data; s = sel; AB = 16'h0000;
   endtask

   initial begin
      logic [7:0] d;
      logic s;
      src = 8'h01;
      #1 reset = 1'b1;
      #1 chk("IRQ in reset", {7'd0, IRQ}, 8'h01);
      chk("NMI in reset", {7'd0, NMI}, 8'h01);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      bus_rd(16'hD000, d, s);
      chk("held src no pend", d, 8'h00);
      chk("held src IRQ", {7'd0, IRQ}, 8'h01);

      src[0] = 1'b0;
      repeat (3) @(negedge clk);
      src[0] = 1'b1;
      repeat (3) @(negedge clk);
      bus_rd(16'hD000, d, s);
      chk("pend0 set", d, 8'h01);
      chk("masked IRQ", {7'd0, IRQ}, 8'h01);
      bus_wr(16'hD000, 8'h01, 1'b1);

      bus_wr(16'hD001, 8'h05, 1'b1);
      src[2] = 1'b1;
      repeat (2) @(negedge clk);
      chk("IRQ k+1", {7'd0, IRQ}, 8'h01);
      @(negedge clk);
      chk("IRQ k+2", {7'd0, IRQ}, 8'h00);
      bus_rd(16'hD002, d, s);
      chk("cause 82", d, 8'h82);
      chk("sel hit", {7'd0, s}, 8'h01);
      bus_wr(16'hD000, 8'h04, 1'b1);
      chk("IRQ after w1c", {7'd0, IRQ}, 8'h01);
      bus_rd(16'hD000, d, s);
      chk("status 00", d, 8'h00);

      bus_wr(16'hD001, 8'hFF, 1'b1);
      src[6] = 1'b1; src[3] = 1'b1;
      repeat (3) @(negedge clk);
      bus_rd(16'hD002, d, s);
      chk("cause 83", d, 8'h83);
      bus_wr(16'hD000, 8'h08, 1'b1);
      bus_rd(16'hD002, d, s);
      chk("cause 86", d, 8'h86);
      bus_wr(16'hD000, 8'h40, 1'b1);
      bus_rd(16'hD002, d, s);
      chk("cause 00", d, 8'h00);
      chk("IRQ idle", {7'd0, IRQ}, 8'h01);

      src[1] = 1'b1;
      repeat (2) @(negedge clk);
      bus_wr(16'hD000, 8'h02, 1'b1);
      bus_rd(16'hD000, d, s);
      chk("set wins", d, 8'h02);
      chk("set wins IRQ", {7'd0, IRQ}, 8'h00);
      bus_wr(16'hD000, 8'h02, 1'b1);

      bus_wr(16'hD001, 8'h00, 1'b0);
      bus_rd(16'hD001, d, s);
      chk("RDY=0 write", d, 8'hFF);
      bus_rd(16'hD004, d, s);
      chk("sel miss", {7'd0, s}, 8'h00);

      nmi_src = 1'b1;
      repeat (2) @(negedge clk);
      chk("NMI k+1", {7'd0, NMI}, 8'h01);
      @(negedge clk);
      chk("NMI k+2", {7'd0, NMI}, 8'h00);
      bus_rd(16'hD003, d, s);
      chk("nmictl 01", d, 8'h01);
      bus_wr(16'hD003, 8'h01, 1'b1);
      chk("NMI cleared", {7'd0, NMI}, 8'h01);
      nmi_src = 1'b0;
      repeat (3) @(negedge clk);
      nmi_src = 1'b1;
      repeat (4) @(negedge clk);
      chk("NMI again", {7'd0, NMI}, 8'h00);
      #2 reset = 1'b1;
      #1 chk("NMI async reset", {7'd0, NMI}, 8'h01);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0)
            src = src ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0)
            nmi_src = ~nmi_src;
         case ($urandom_range(0, 5))
            0, 1, 2, 3: AB = 16'hD000 + 16'($urandom_range(0, 3));
            4:          AB = 16'hD004;
            default:    AB = 16'hCFFF;
         endcase
         WE  = $urandom_range(0, 2) == 0;
         RDY = $urandom_range(0, 3) != 0;
         DO  = 8'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      WE = 1'b0;
      AB = 16'h0000;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that sits directly upstream of the 6502 cpu core.
- Collects up to 8 peripheral interrupt sources plus one NMI source, and latches their rising edges as pending bits.
- Drives the core's active-low IRQ and NMI inputs.
- Exposes status, enable, cause and NMI-control registers on the cpu bus (AB/DO/WE/RDY), with read data returned on the same synchronous-read timing as the system RAM.

Parameters:
- BASE, 16'hD000: register window base address; bits [1:0] must be 0. The window is BASE..BASE+3.
- NSRC, 8: number of maskable sources, 1..8. Register bits NSRC..7 read 0 and ignore writes.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- AB  in  16  cpu address bus.
- DO  in  8  cpu write data.
- WE  in  1  cpu write enable, active high.
- RDY  in  1  cpu ready; register writes are qualified by RDY=1.
- src  in  NSRC  asynchronous interrupt sources, rising-edge sensitive.
- nmi_src  in  1  asynchronous NMI source, rising-edge sensitive.
- rd_data  out  8  registered read data for the top-level DI mux.
- sel  out  1  registered: the previous-cycle AB hit the window; the top level selects rd_data onto DI when sel=1.
- IRQ  out  1  to cpu, active low.
- NMI  out  1  to cpu, active low.

Behaviour:
- Reset (async, active-high) clears: pend, en, nmi_pend, all synchroniser/edge flops, rd_data=0, sel=0, and arm counter=0. IRQ=1 and NMI=1 during and after reset.
- hit = (AB[15:2] == BASE[15:2]); off = AB[1:0].
- Register map:
  - 0 STATUS: R returns pend. W is write-1-to-clear.
  - 1 ENABLE: R/W en.
  - 2 CAUSE: R only. bit7 = |(pend&en); bits[2:0] = lowest index i with pend[i]&en[i]; 8'h00 when none. W ignored.
  - 3 NMICTL: R returns bit0=nmi_pend, other bits 0. W bit0=1 clears nmi_pend.
- Reads: on every clock edge, sel<=hit and rd_data<=register[off], sampled from register state before that edge's updates. This gives 1-cycle latency, matching the RAM. rd_data is don't-care when sel=0.
- Writes: take effect on the edge where hit & WE & RDY. There are no side effects when RDY=0.
- Synchroniser: each of src and nmi_src passes through 2 flops (s1, s2) followed by a prev flop; edge = s2 & ~prev.
  - An input first sampled high at edge k sets its pending bit at edge k+2.
  - IRQ/NMI are combinational from registers and go low after edge k+2.
- Arming: a 2-bit counter saturates at 3 after reset release. Edges are discarded while counter<3, i.e. during the first 3 edges after reset. The synchroniser and prev flops still track during this time. Consequence: a source held high through reset never sets pending.
- IRQ = ~|(pend & en). Masked pending bits stay latched; setting en later asserts IRQ immediately after that write edge.
- NMI = ~nmi_pend. It is held low until software clears it; the core edge-detects the falling edge.
- Simultaneous set and clear on the same edge: set wins, so a new edge is never lost. This applies per bit, for both pend and nmi_pend.
- Repeated rising edges while a bit is already pending merge into the one pending bit; there is no counting.
- Reset mid-operation discards all pending state and synchroniser state. Re-arming follows the arming rule.
- Source pulses shorter than 1 clk may be missed. Sources must hold each level for at least 2 clk.

Test Plan:
- Reset release with src=8'h01 held high: after 10 clk, pend=0, IRQ=1. Drop src[0] low for 3 clk, then high: pend[0]=1 two edges after the high sample. Because en=0, IRQ stays 1.
- Write ENABLE=8'h05 at D001 (WE=1, RDY=1), then pulse src[2]: IRQ=0 two edges after sample. Read D002 → next-cycle rd_data=8'h82, sel=1. Write 8'h04 to D000 → IRQ=1 after that edge, and STATUS reads 8'h00.
- en=8'hFF, pulse src[6] and src[3] together → CAUSE=8'h83. Clear bit3 → CAUSE=8'h86. Clear bit6 → CAUSE=8'h00, IRQ=1.
- Rising edge on src[1] on the same edge as a W1C write of 8'h02 to D000 → pend[1] remains 1 and IRQ stays low (en[1]=1).
- Write to D001 with RDY=0 → en unchanged. Read of address D004 (outside the window) → sel=0.
- Pulse nmi_src → NMI=0 two edges after sample. Read D003 → 8'h01. Write 8'h01 to D003 → NMI=1. Assert reset while nmi_pend=1 → NMI=1 immediately (async).
